// File: rtl/irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : irq_controller
// Purpose  : Latches rising edges on device interrupt lines as pending bits,
//            masks them, and raises one external interrupt request at a time.
//            The request goes to the lowest-index enabled pending source and
//            is held until the core acknowledges it.
// Revision : 1.0 - initial release
// ============================================================================
module irq_controller #(
  parameter int N_SRC = 4,
  parameter int ID_W  = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_SRC-1:0] irq_in,
  input  logic [N_SRC-1:0] irq_mask,
  input  logic             ExtIAck,
  output logic             ExtIRQ,
  output logic [ID_W-1:0]  irq_id,
  output logic [N_SRC-1:0] pending,
  output logic [7:0]       ack_count,
  output logic             spurious_ack
);

  // IDLE: look for work; REQ: request held until ack; DONE: one dead cycle
  // so the combinational ack falls before the next request can rise.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_SRC-1:0] irq_in_q;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] eligible;
  logic [N_SRC-1:0] id_onehot;
  logic [N_SRC-1:0] retire;
  logic [ID_W-1:0]  irq_id_q, irq_id_d;
  logic [ID_W-1:0]  winner;
  logic [7:0]       ack_count_q, ack_count_d;
  logic             spurious_q, spurious_d;
  logic             any_eligible;

  // Previous-cycle copy of the lines. It keeps sampling through reset so a
  // line that is already high when reset lifts is not seen as a new edge.
  always_ff @(posedge clk) begin
    irq_in_q <= irq_in;
  end

  // Edge detection, eligibility and lowest-index priority selection.
  always_comb begin
    rise         = irq_in & ~irq_in_q;
    eligible     = pending_q & irq_mask;
    any_eligible = |eligible;
    winner       = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (eligible[i]) begin
        winner = ID_W'(i);
      end
    end
  end

  // One-hot decode of the source currently being requested.
  always_comb begin
    id_onehot = '0;
    for (int i = 0; i < N_SRC; i++) begin
      id_onehot[i] = (irq_id_q == ID_W'(i));
    end
  end

  // Next-state logic and request output.
  always_comb begin
    state_d     = state_q;
    irq_id_d    = irq_id_q;
    ack_count_d = ack_count_q;
    retire      = '0;
    ExtIRQ      = 1'b0;
    spurious_d  = spurious_q | (ExtIAck && (state_q != ST_REQ));
    case (state_q)
      ST_IDLE: begin
        if (any_eligible) begin
          irq_id_d = winner;
          state_d  = ST_REQ;
        end
      end
      ST_REQ: begin
        // Neither a newly arrived higher-priority source nor a mask change
        // disturbs a request once it is raised.
        ExtIRQ = 1'b1;
        if (ExtIAck) begin
          retire  = id_onehot;
          state_d = ST_DONE;
          if (ack_count_q != 8'hFF) begin
            ack_count_d = ack_count_q + 8'd1;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    // A fresh edge on the retiring source in the same cycle keeps it pending.
    pending_d = (pending_q & ~retire) | rise;
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      irq_id_q    <= '0;
      pending_q   <= '0;
      ack_count_q <= 8'd0;
      spurious_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      irq_id_q    <= irq_id_d;
      pending_q   <= pending_d;
      ack_count_q <= ack_count_d;
      spurious_q  <= spurious_d;
    end
  end

  assign irq_id       = irq_id_q;
  assign pending      = pending_q;
  assign ack_count    = ack_count_q;
  assign spurious_ack = spurious_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_irq_controller
// Purpose  : Self-checking bench for irq_controller: directed scenarios plus a
//            randomized phase, all compared every cycle with a behavioural
//            model of pending bits, request ownership and counters.
// Revision : 1.0 - initial release
// ============================================================================
module tb_irq_controller;

  logic       clk;
  logic       reset;
  logic [3:0] irq_in;
  logic [3:0] irq_mask;
  logic       ExtIAck;
  logic       ExtIRQ;
  logic [1:0] irq_id;
  logic [3:0] pending;
  logic [7:0] ack_count;
  logic       spurious_ack;

  int n_assert = 0;
  int n_fail   = 0;

  // Behavioural model state
  logic [3:0] m_pend;
  logic [3:0] m_prev;
  bit         m_req;
  int         m_id;
  int         m_cool;
  int         m_cnt;
  bit         m_spur;

  int base;

  irq_controller #(.N_SRC(4), .ID_W(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .irq_in      (irq_in),
    .irq_mask    (irq_mask),
    .ExtIAck     (ExtIAck),
    .ExtIRQ      (ExtIRQ),
    .irq_id      (irq_id),
    .pending     (pending),
    .ack_count   (ack_count),
    .spurious_ack(spurious_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Model: one clock edge, computed from the rules of the handshake.
  task automatic model_update();
    logic [3:0] rise;
    logic [3:0] elig;
    rise   = irq_in & ~m_prev;
    m_prev = irq_in;
    if (reset) begin
      m_pend = 4'd0; m_req = 0; m_id = 0; m_cool = 0; m_cnt = 0; m_spur = 0;
    end else begin
      if (ExtIAck && !m_req) m_spur = 1;
      elig = m_pend & irq_mask;
      if (m_req && ExtIAck) begin
        m_pend[m_id] = 1'b0;
        m_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
        m_req  = 0;
        m_cool = 1;
      end else if (m_req) begin
        m_req = 1;
      end else if (m_cool > 0) begin
        m_cool--;
      end else if (elig != 4'd0) begin
        for (int i = 0; i < 4; i++) begin
          if (elig[i]) begin
            m_id = i;
            break;
          end
        end
        m_req = 1;
      end
      m_pend = m_pend | rise;
    end
  endtask

  task automatic check_all();
    check("ExtIRQ", ExtIRQ, m_req);
    if (m_req) check("irq_id", irq_id, m_id);
    check("pending", pending, m_pend);
    check("ack_count", ack_count, m_cnt);
    check("spurious_ack", spurious_ack, m_spur);
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_all();
  endtask

  task automatic wait_req();
    for (int k = 0; k < 20 && !ExtIRQ; k++) step();
    check("wait_req", ExtIRQ, 1);
  endtask

  task automatic ack_and_done();
    ExtIAck = 1'b1;
    step();
    ExtIAck = 1'b0;
    step();
  endtask

  initial begin
    m_prev = 4'd0; m_pend = 4'd0; m_req = 0; m_id = 0; m_cool = 0; m_cnt = 0; m_spur = 0;
    reset = 1'b1; irq_in = 4'd0; irq_mask = 4'hF; ExtIAck = 1'b0;
    step(); step();
    reset = 1'b0;
    step();

    // Reset in the middle of a request
    irq_in = 4'b0100;
    wait_req();
    reset = 1'b1;
    step();
    check("reset_midreq_irq", ExtIRQ, 0);
    check("reset_midreq_pend", pending, 0);
    reset = 1'b0;
    repeat (5) step();
    check("reset_hold_noreq", ExtIRQ, 0);
    irq_in = 4'd0;
    step();

    // Single source timing
    irq_in = 4'b0010;
    step();
    check("single_pend", pending, 4'b0010);
    check("single_irq_early", ExtIRQ, 0);
    step();
    check("single_irq", ExtIRQ, 1);
    check("single_id", irq_id, 1);
    step();
    ExtIAck = 1'b1;
    step();
    ExtIAck = 1'b0;
    check("single_cleared", pending, 0);
    check("single_irq_done", ExtIRQ, 0);
    step();
    check("single_irq_idle", ExtIRQ, 0);
    irq_in = 4'd0;
    step();

    // Priority and no preemption
    irq_in = 4'b1010;
    wait_req();
    check("prio_first", irq_id, 1);
    ack_and_done();
    wait_req();
    check("prio_second", irq_id, 3);
    irq_in = 4'b1011;
    step(); step();
    check("no_preempt", irq_id, 3);
    ack_and_done();
    wait_req();
    check("prio_third", irq_id, 0);
    ack_and_done();
    irq_in = 4'd0;
    step();

    // Masking
    irq_mask = 4'b1110;
    irq_in   = 4'b0001;
    repeat (4) step();
    check("mask_irq", ExtIRQ, 0);
    check("mask_pend", pending[0], 1);
    irq_mask = 4'hF;
    step();
    check("unmask_irq", ExtIRQ, 1);
    check("unmask_id", irq_id, 0);
    ack_and_done();
    irq_in = 4'd0;
    step();

    // Level held high: one request only
    base   = m_cnt;
    irq_in = 4'b0100;
    wait_req();
    ack_and_done();
    repeat (15) step();
    irq_in = 4'd0;
    repeat (3) step();
    check("held_level_count", ack_count, base + 1);

    // Re-rise in the acknowledge cycle
    irq_in = 4'b0100;
    wait_req();
    irq_in = 4'd0;
    step();
    ExtIAck = 1'b1;
    irq_in  = 4'b0100;
    step();
    ExtIAck = 1'b0;
    check("rerise_pend", pending[2], 1);
    step();
    step();
    check("rerise_irq", ExtIRQ, 1);
    check("rerise_id", irq_id, 2);
    ack_and_done();
    irq_in = 4'd0;
    repeat (2) step();

    // Spurious acknowledge in IDLE
    base    = m_cnt;
    ExtIAck = 1'b1;
    step();
    ExtIAck = 1'b0;
    check("spurious_flag", spurious_ack, 1);
    check("spurious_count", ack_count, base);
    step();

    // Saturation of the acknowledge counter
    for (int n = 0; n < 260; n++) begin
      irq_in = 4'b0001;
      step();
      irq_in = 4'd0;
      wait_req();
      ack_and_done();
    end
    check("saturate", ack_count, 255);

    // Randomized phase
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int n = 0; n < 800; n++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 5) == 0) irq_in[b] = ~irq_in[b];
      end
      if ($urandom_range(0, 7) == 0) irq_mask = 4'($urandom_range(0, 15));
      ExtIAck = (m_req && ($urandom_range(0, 2) == 0)) || ($urandom_range(0, 99) == 0);
      reset   = ($urandom_range(0, 149) == 0);
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
